prime_test: RTL

//   Trial-division primality tester; sits directly upstream of divmod and drives it.

---
 rtl/prime_test_if.sv | 30 +++
 rtl/prime_test.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/prime_test_if.sv
// Bundles the request/result handshake and the divider-facing signals of prime_test.
// The DUT uses the slave modport; the environment (requester plus divider) uses master.
interface prime_test_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] n;
  logic             busy;
  logic             done;
  logic             is_prime;
  logic [WIDTH-1:0] factor;
  logic             err;
  logic             div_go;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_ready;
  logic             div_error;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;

  modport master (
    output start, n, div_ready, div_error, div_q, div_r,
    input  busy, done, is_prime, factor, err, div_go, div_a, div_b
  );

  modport slave (
    input  start, n, div_ready, div_error, div_q, div_r,
    output busy, done, is_prime, factor, err, div_go, div_a, div_b
  );
endinterface

// File: rtl/prime_test.sv
// Trial-division primality tester that drives an external divmod unit.
// Divides N by 2, 3, 5, 7, ... until a zero remainder (composite) or quotient < d (prime).
//
// Handshake: start is level-sampled and only taken in IDLE (n captured on that cycle);
// busy is high from accept until done; done is a one-cycle pulse with is_prime/factor/err
// valid and held until the next accept. Towards the divider, div_go pulses once per
// division with div_a/div_b stable; div_ready falling is the divider's accept, and
// div_ready rising again marks div_q/div_r/div_error valid.
module prime_test #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  prime_test_if.slave bus,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_EVAL      = 3'd4,
    S_FIN       = 3'd5
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_d;
  logic             r_busy;
  logic             r_done;
  logic             r_is_prime;
  logic [WIDTH-1:0] r_factor;
  logic             r_err;
  logic             r_div_go;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_n_nxt;
  logic [WIDTH-1:0] w_d_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_is_prime_nxt;
  logic [WIDTH-1:0] w_factor_nxt;
  logic             w_err_nxt;
  logic             w_div_go_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_d        <= WIDTH'(2);
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_is_prime <= 1'b0;
      r_factor   <= '0;
      r_err      <= 1'b0;
      r_div_go   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_n        <= w_n_nxt;
      r_d        <= w_d_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_is_prime <= w_is_prime_nxt;
      r_factor   <= w_factor_nxt;
      r_err      <= w_err_nxt;
      r_div_go   <= w_div_go_nxt;
    end
  end

  // div_go is registered, so it is raised on every transition into ISSUE and is
  // therefore high for exactly the ISSUE cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_n_nxt        = r_n;
    w_d_nxt        = r_d;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_is_prime_nxt = r_is_prime;
    w_factor_nxt   = r_factor;
    w_err_nxt      = r_err;
    w_div_go_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_n_nxt        = bus.n;
          w_d_nxt        = WIDTH'(2);
          w_busy_nxt     = 1'b1;
          w_is_prime_nxt = 1'b0;
          w_factor_nxt   = '0;
          w_err_nxt      = 1'b0;
          if (bus.n <= WIDTH'(1)) begin
            w_state_nxt = S_FIN;
          end else if (bus.n == WIDTH'(2)) begin
            w_is_prime_nxt = 1'b1;
            w_state_nxt    = S_FIN;
          end else begin
            w_div_go_nxt = 1'b1;
            w_state_nxt  = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        w_state_nxt = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (bus.div_ready && bus.div_error) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_FIN;
        end else if (!bus.div_ready) begin
          w_state_nxt = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (bus.div_ready) begin
          if (bus.div_error) begin
            w_err_nxt      = 1'b1;
            w_is_prime_nxt = 1'b0;
            w_state_nxt    = S_FIN;
          end else begin
            w_state_nxt = S_EVAL;
          end
        end
      end

      // Remainder test has priority: N = d*d must report composite, not prime.
      S_EVAL: begin
        if (bus.div_r == '0) begin
          w_is_prime_nxt = 1'b0;
          w_factor_nxt   = r_d;
          w_state_nxt    = S_FIN;
        end else if (bus.div_q < r_d) begin
          w_is_prime_nxt = 1'b1;
          w_factor_nxt   = '0;
          w_state_nxt    = S_FIN;
        end else begin
          w_d_nxt      = (r_d == WIDTH'(2)) ? WIDTH'(3) : r_d + WIDTH'(2);
          w_div_go_nxt = 1'b1;
          w_state_nxt  = S_ISSUE;
        end
      end

      S_FIN: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.is_prime = r_is_prime;
  assign bus.factor   = r_factor;
  assign bus.err      = r_err;
  assign bus.div_go   = r_div_go;
  assign bus.div_a    = r_n;
  assign bus.div_b    = r_d;
  assign o_dbg_state  = r_state;

endmodule
